// File: rtl/score_counter_if.sv
// Score counter bus: pushbutton requests and clear in, BCD digits and status flags out.
interface score_counter_if;
    logic       count_up_i;
    logic       count_down_i;
    logic       clear_i;
    logic [3:0] tens_o;
    logic [3:0] ones_o;
    logic       max_o;
    logic       flash_o;

    modport master (
        output count_up_i, count_down_i, clear_i,
        input  tens_o, ones_o, max_o, flash_o
    );

    modport slave (
        input  count_up_i, count_down_i, clear_i,
        output tens_o, ones_o, max_o, flash_o
    );
endinterface

// File: rtl/score_counter.sv
// Two-digit BCD team score driven by edge-detected up/down pulses, with a
// max-score flag and a retriggerable change flash.
module score_counter #(
    parameter int MAX_SCORE  = 99,
    parameter int WRAP       = 0,
    parameter int FLASH_TIME = 250
) (
    input  logic                  clk_1khz,
    input  logic                  rst_i,
    score_counter_if.slave        bus
);
    localparam logic [3:0] MAX_TENS   = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_ONES   = 4'(MAX_SCORE % 10);
    localparam logic [9:0] FLASH_LOAD = 10'(FLASH_TIME);

    logic       up_d, down_d;
    logic       up_evt, dn_evt;
    logic [3:0] tens_q, ones_q;
    logic [3:0] tens_nxt, ones_nxt;
    logic       changed;
    logic       at_max, at_zero;
    logic [9:0] flash_cnt, flash_cnt_nxt;
    logic       flash_q;

    assign up_evt  = bus.count_up_i & ~up_d;
    assign dn_evt  = bus.count_down_i & ~down_d;
    assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        tens_nxt = tens_q;
        ones_nxt = ones_q;
        changed  = 1'b0;
        if (up_evt && !dn_evt) begin
            if (at_max) begin
                if (WRAP != 0) begin
                    tens_nxt = '0;
                    ones_nxt = '0;
                    changed  = 1'b1;
                end
            end else if (ones_q == 4'd9) begin
                ones_nxt = '0;
                tens_nxt = tens_q + 4'd1;
                changed  = 1'b1;
            end else begin
                ones_nxt = ones_q + 4'd1;
                changed  = 1'b1;
            end
        end else if (dn_evt && !up_evt) begin
            if (at_zero) begin
                if (WRAP != 0) begin
                    tens_nxt = MAX_TENS;
                    ones_nxt = MAX_ONES;
                    changed  = 1'b1;
                end
            end else if (ones_q == 4'd0) begin
                ones_nxt = 4'd9;
                tens_nxt = tens_q - 4'd1;
                changed  = 1'b1;
            end else begin
                ones_nxt = ones_q - 4'd1;
                changed  = 1'b1;
            end
        end
    end

    // flash_q is registered from the next counter value so it rises with the update
    always_comb begin
        flash_cnt_nxt = flash_cnt;
        if (bus.clear_i)
            flash_cnt_nxt = '0;
        else if (changed)
            flash_cnt_nxt = FLASH_LOAD;
        else if (flash_cnt != '0)
            flash_cnt_nxt = flash_cnt - 10'd1;
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            up_d      <= 1'b0;
            down_d    <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
            flash_cnt <= '0;
            flash_q   <= 1'b0;
        end else begin
            up_d      <= bus.count_up_i;
            down_d    <= bus.count_down_i;
            flash_cnt <= flash_cnt_nxt;
            flash_q   <= (flash_cnt_nxt != '0);
            if (bus.clear_i) begin
                tens_q <= '0;
                ones_q <= '0;
            end else begin
                tens_q <= tens_nxt;
                ones_q <= ones_nxt;
            end
        end
    end

    assign bus.tens_o  = tens_q;
    assign bus.ones_o  = ones_q;
    assign bus.max_o   = at_max;
    assign bus.flash_o = flash_q;
endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: a saturating and a wrapping instance share
// the same request stimulus.
module tb_score_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up  = 1'b0;
    logic dn  = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    score_counter_if bus ();
    score_counter_if bus_w ();

    assign bus.count_up_i     = up;
    assign bus.count_down_i   = dn;
    assign bus.clear_i        = clr;
    assign bus_w.count_up_i   = up;
    assign bus_w.count_down_i = dn;
    assign bus_w.clear_i      = clr;

    score_counter #(.MAX_SCORE(99), .WRAP(0), .FLASH_TIME(250)) dut (
        .clk_1khz (clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    score_counter #(.MAX_SCORE(99), .WRAP(1), .FLASH_TIME(250)) dut_w (
        .clk_1khz (clk),
        .rst_i    (rst),
        .bus      (bus_w)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int score();
        return int'(bus.tens_o) * 10 + int'(bus.ones_o);
    endfunction

    function automatic int score_w();
        return int'(bus_w.tens_o) * 10 + int'(bus_w.ones_o);
    endfunction

    task automatic pulse_up(input int hold, input int gap);
        up = 1'b1;
        repeat (hold) tick();
        up = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        up  = 1'b0;
        dn  = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;

        // reset state
        do_reset();
        check("rst_score", score(), 0);
        check("rst_max", int'(bus.max_o), 0);
        check("rst_flash", int'(bus.flash_o), 0);

        // down at 00: saturate vs wrap
        dn = 1'b1;
        tick();
        check("sat_dn0_score", score(), 0);
        check("sat_dn0_flash", int'(bus.flash_o), 0);
        check("wrap_dn0_score", score_w(), 99);
        check("wrap_dn0_flash", int'(bus_w.flash_o), 1);
        check("wrap_dn0_max", int'(bus_w.max_o), 1);
        dn = 1'b0;
        tick();

        // three 10-cycle up pulses, 20 cycles apart
        do_reset();
        for (int p = 1; p <= 3; p++) begin
            up = 1'b1;
            check($sformatf("up%0d_before", p), score(), p - 1);
            tick();
            check($sformatf("up%0d_after", p), score(), p);
            repeat (9) tick();
            check($sformatf("up%0d_held", p), score(), p);
            up = 1'b0;
            repeat (20) tick();
        end
        check("up3_flash", int'(bus.flash_o), 1);

        // climb to 99, let flash expire, then one more up
        for (int i = 0; i < 96; i++) pulse_up(1, 1);
        check("climb_score", score(), 99);
        check("climb_max", int'(bus.max_o), 1);
        repeat (260) tick();
        check("climb_flash_off", int'(bus.flash_o), 0);
        check("climb_flash_off_w", int'(bus_w.flash_o), 0);
        up = 1'b1;
        tick();
        check("sat_up99_score", score(), 99);
        check("sat_up99_max", int'(bus.max_o), 1);
        check("sat_up99_flash", int'(bus.flash_o), 0);
        check("wrap_up99_score", score_w(), 0);
        check("wrap_up99_max", int'(bus_w.max_o), 0);
        n = 0;
        while (bus_w.flash_o && n < 2000) begin
            n++;
            tick();
        end
        check("wrap_flash_len", n, 250);
        up = 1'b0;
        tick();

        // 10 -> 09 across the ones borrow
        do_reset();
        for (int i = 0; i < 10; i++) pulse_up(1, 1);
        check("pre_dn_score", score(), 10);
        dn = 1'b1;
        tick();
        check("dn10_score", score(), 9);
        check("dn10_flash", int'(bus.flash_o), 1);
        dn = 1'b0;
        tick();

        // simultaneous up and down at 05
        do_reset();
        for (int i = 0; i < 5; i++) pulse_up(1, 1);
        repeat (260) tick();
        up = 1'b1;
        dn = 1'b1;
        tick();
        check("both_score", score(), 5);
        check("both_flash", int'(bus.flash_o), 0);
        up = 1'b0;
        dn = 1'b0;
        tick();

        // clear at 07 while up held high
        do_reset();
        for (int i = 0; i < 7; i++) pulse_up(1, 1);
        check("pre_clr_flash", int'(bus.flash_o), 1);
        up  = 1'b1;
        clr = 1'b1;
        tick();
        check("clr_score", score(), 0);
        check("clr_flash", int'(bus.flash_o), 0);
        clr = 1'b0;
        tick();
        check("clr_release_score", score(), 0);
        up = 1'b0;
        tick();

        // retrigger: second change 100 cycles after the first
        do_reset();
        up = 1'b1;
        tick();
        n = 0;
        while (bus.flash_o && n < 2000) begin
            if (n == 3) up = 1'b0;
            if (n == 99) up = 1'b1;
            if (n == 102) up = 1'b0;
            n++;
            tick();
        end
        check("retrig_len", n, 350);
        check("retrig_score", score(), 2);

        // reset mid-flash with up held across reset release
        up = 1'b1;
        tick();
        check("midflash_flash", int'(bus.flash_o), 1);
        rst = 1'b1;
        tick();
        check("midrst_score", score(), 0);
        check("midrst_flash", int'(bus.flash_o), 0);
        check("midrst_max", int'(bus.max_o), 0);
        rst = 1'b0;
        tick();
        check("post_rst_held_up", score(), 1);
        repeat (3) tick();
        check("post_rst_no_recount", score(), 1);
        up = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Downstream consumer of the pushbutton processor's `count_up` / `count_down` pulses.
- Holds one team's score as a two-digit BCD value, 00..MAX_SCORE, and feeds the 7-segment display driver.
- Each upstream pulse lasts several ticks; this block edge-detects it so one press changes the score by exactly one.
- Also provides a max-score flag and a timed change-indication (flash) output.

Parameters:
- MAX_SCORE, 99: upper score limit, decimal; legal range 1..99.
- WRAP, 0: 0 = saturate at 0 and MAX_SCORE; 1 = wrap MAX_SCORE↔0.
- FLASH_TIME, 250: flash_o duration in clk_1khz ticks; legal range 1..1023.

Ports:
- clk_1khz  input  1  1 kHz system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active high.
- count_up_i  input  1  increment request; multi-cycle high pulse from pushbutton processor.
- count_down_i  input  1  decrement request; multi-cycle high pulse.
- clear_i  input  1  synchronous level clear of the score.
- tens_o  output  4  BCD tens digit, registered.
- ones_o  output  4  BCD ones digit, registered.
- max_o  output  1  high while score == MAX_SCORE; combinational from digit registers.
- flash_o  output  1  high for FLASH_TIME cycles after any score change.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - tens_o=0, ones_o=0, flash_o=0, flash counter=0.
  - Edge registers up_d=0, down_d=0.
  - max_o follows the score, i.e. 0.
  - Reset mid-flash or mid-pulse aborts everything.
  - A request still high after reset release counts once, because up_d/down_d restart at 0.
- Edge detection:
  - up_d <= count_up_i and down_d <= count_down_i every cycle.
  - up_evt = count_up_i & ~up_d; dn_evt = count_down_i & ~down_d.
  - Held-high inputs produce no further events.
- Update latency: score registers change on the same clock edge at which the event is detected (first edge sampling the input high). New value is visible one cycle after the input rises.
- Priority per edge: rst_i > clear_i > (up_evt & dn_evt) > single event.
- clear_i=1:
  - Score becomes 00 and the flash counter becomes 0 (flash_o low next cycle).
  - Edge registers still track their inputs, so a pulse held across the clear is not re-counted.
- up_evt & dn_evt in the same cycle: no score change and no flash.
- Increment:
  - ones==9 → ones=0 and tens+1; otherwise ones+1.
  - At MAX_SCORE: WRAP=0 → unchanged, no flash; WRAP=1 → 00 with flash.
- Decrement:
  - ones==0 → ones=9 and tens−1; otherwise ones−1.
  - At 00: WRAP=0 → unchanged, no flash; WRAP=1 → BCD(MAX_SCORE) with flash.
- Digits never hold non-BCD values. Comparison against MAX_SCORE uses the BCD encoding: tens = MAX_SCORE/10, ones = MAX_SCORE%10.
- Flash:
  - Any actual score change (not clear) loads the flash counter with FLASH_TIME.
  - flash_o = (counter != 0), registered. The counter decrements each cycle while non-zero.
  - flash_o is therefore high for exactly FLASH_TIME cycles, starting the cycle after the update.
  - A new change during flash reloads the counter (retrigger, no gap).
- Flash counter width is 10 bits; no other arithmetic overflow is possible.

Test Plan:
- Reset, then three count_up_i pulses of 10 cycles each, 20 cycles apart → tens/ones go 00→01→02→03, each change one cycle after the rising edge; exactly +1 per pulse.
- Preload to 99 (MAX_SCORE=99, WRAP=0), one up pulse → stays 99, max_o=1, flash_o stays 0. Then WRAP=1 build, same stimulus → 00 and flash_o high for 250 cycles.
- Score 10, one down pulse → 09; score 00 with WRAP=0 and a down pulse → 00, no flash.
- count_up_i and count_down_i rising on the same edge at score 05 → stays 05, flash_o=0.
- Score 07 with flash active, clear_i high for 1 cycle while count_up_i is held high → 00, flash_o low next cycle, no increment when clear deasserts.
- Two up pulses 100 cycles apart with FLASH_TIME=250 → flash_o continuously high from the first change until 250 cycles after the second change; rst_i asserted mid-flash → all outputs 0 next cycle.
